// File: rtl/fs_bist_pkg.sv
// Shared types and constants for the full-subtractor self-test checker.
package fs_bist_pkg;

    localparam int unsigned VEC_W = 3;
    localparam logic [VEC_W-1:0] LAST_VEC = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Stimulus presented to the subtractor under test
    typedef struct packed {
        logic a;
        logic b;
        logic bin;
    } sub_in_t;

    // Response returned by the subtractor under test
    typedef struct packed {
        logic diff;
        logic bout;
    } sub_out_t;

    function automatic sub_in_t vec_to_in(input logic [VEC_W-1:0] v);
        return sub_in_t'(v);
    endfunction

endpackage

// File: rtl/fs_golden.sv
// Reference full subtractor; purely combinational expected diff/bout.
module fs_golden
    import fs_bist_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic exp_diff_c_o,
    output logic exp_bout_c_o
);

    assign exp_diff_c_o = a_i ^ b_i ^ bin_i;
    assign exp_bout_c_o = (~a_i & b_i) | (~a_i & bin_i) | (b_i & bin_i);

endmodule

// File: rtl/fs_bist_checker.sv
// Sweeps all 8 {a,b,bin} vectors into a full subtractor, holds each for DWELL
// cycles, checks the sampled response against a golden model and reports results.
module fs_bist_checker
    import fs_bist_pkg::*;
#(
    parameter int unsigned DWELL = 10,
    parameter int unsigned ERR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a,
    output logic             b,
    output logic             bin,
    input  logic             diff,
    input  logic             bout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [VEC_W-1:0] fail_vec
);

    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [CNT_W-1:0]   dwell_q, dwell_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [VEC_W-1:0]   fail_vec_q, fail_vec_d;
    sub_in_t            stim_q, stim_d;
    sub_out_t           smp_q, smp_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;

    logic               exp_diff_c, exp_bout_c;
    sub_out_t           exp_c;
    logic               mismatch_c;

    fs_golden u_golden (
        .a_i          (vec_q[2]),
        .b_i          (vec_q[1]),
        .bin_i        (vec_q[0]),
        .exp_diff_c_o (exp_diff_c),
        .exp_bout_c_o (exp_bout_c)
    );

    assign exp_c = '{diff: exp_diff_c, bout: exp_bout_c};

    // Anything other than a proven match (including X/Z in simulation) is a mismatch
    always_comb begin
        mismatch_c = 1'b1;
        if (smp_q == exp_c) begin
            mismatch_c = 1'b0;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        dwell_d    = dwell_q;
        err_d      = err_q;
        fail_vec_d = fail_vec_q;
        stim_d     = stim_q;
        smp_d      = smp_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = APPLY;
                    vec_d      = '0;
                    dwell_d    = '0;
                    err_d      = '0;
                    fail_vec_d = '0;
                    stim_d     = vec_to_in('0);
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                end
            end

            APPLY: begin
                if (dwell_q == DWELL_LAST) begin
                    smp_d   = '{diff: diff, bout: bout};
                    state_d = CHECK;
                end else begin
                    dwell_d = dwell_q + CNT_W'(1);
                end
            end

            CHECK: begin
                if (mismatch_c) begin
                    if (err_q == '0) begin
                        fail_vec_d = vec_q;
                    end
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + ERR_W'(1);
                    end
                end
                if (vec_q == LAST_VEC) begin
                    state_d = DONE;
                    stim_d  = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = APPLY;
                    vec_d   = vec_q + VEC_W'(1);
                    dwell_d = '0;
                    stim_d  = vec_to_in(vec_q + VEC_W'(1));
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            vec_q      <= '0;
            dwell_q    <= '0;
            err_q      <= '0;
            fail_vec_q <= '0;
            stim_q     <= '0;
            smp_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            dwell_q    <= dwell_d;
            err_q      <= err_d;
            fail_vec_q <= fail_vec_d;
            stim_q     <= stim_d;
            smp_q      <= smp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    assign a        = stim_q.a;
    assign b        = stim_q.b;
    assign bin      = stim_q.bin;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_cnt  = err_q;
    assign fail_vec = fail_vec_q;

endmodule

// File: tb/tb_fs_bist_checker.sv
// Bench for fs_bist_checker: two instances (DWELL=10/ERR_W=4 and DWELL=1/ERR_W=2)
// driving faulty/healthy subtractor models, checked every cycle against a sweep model.
module tb_fs_bist_checker;

    localparam int unsigned D0 = 10;
    localparam int unsigned W0 = 4;
    localparam int unsigned D1 = 1;
    localparam int unsigned W1 = 2;

    logic clk = 1'b0;
    logic rst;
    logic start;
    int   mode;
    bit   chk_en;
    int   total = 0;
    int   bad = 0;

    logic          a0, b0, bin0, diff0, bout0, busy0, done0, pass0;
    logic [W0-1:0] err0;
    logic [2:0]    fv0;
    logic          a1, b1, bin1, diff1, bout1, busy1, done1, pass1;
    logic [W1-1:0] err1;
    logic [2:0]    fv1;

    always #5 clk = ~clk;

    // Arithmetic reference: a - b - bin, diff is the LSB, bout is the sign
    function automatic logic [1:0] fs_ref(input logic [2:0] v);
        int r;
        r = int'(v[2]) - int'(v[1]) - int'(v[0]);
        return {((r & 1) != 0), (r < 0)};
    endfunction

    // Subtractor under test: 0 healthy, 1 bout stuck 0, 2 diff inverted, 3 diff=a^b
    function automatic logic [1:0] dut_fn(input int m, input logic [2:0] v);
        logic [1:0] g;
        g = fs_ref(v);
        case (m)
            1:       return {g[1], 1'b0};
            2:       return {~g[1], g[0]};
            3:       return {v[2] ^ v[1], g[0]};
            default: return g;
        endcase
    endfunction

    assign {diff0, bout0} = dut_fn(mode, {a0, b0, bin0});
    assign {diff1, bout1} = dut_fn(mode, {a1, b1, bin1});

    fs_bist_checker #(.DWELL(D0), .ERR_W(W0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start),
        .a(a0), .b(b0), .bin(bin0), .diff(diff0), .bout(bout0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .fail_vec(fv0)
    );

    fs_bist_checker #(.DWELL(D1), .ERR_W(W1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start),
        .a(a1), .b(b1), .bin(bin1), .diff(diff1), .bout(bout1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_vec(fv1)
    );

    task automatic chk(input string nm, input int inst, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s inst%0d at %0t: got=%0d want=%0d", nm, inst, $time, act, exp);
        end
    endtask

    // Sweep model: cycles elapsed since the accepted start, and the fault mode of that sweep
    int dw[2];
    int wd[2];
    int k[2];
    bit ran[2];
    int smode[2];

    initial begin
        dw[0] = D0; dw[1] = D1;
        wd[0] = W0; wd[1] = W1;
        for (int i = 0; i < 2; i++) begin
            k[i] = 0; ran[i] = 1'b0; smode[i] = 0;
        end
    end

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                ran[i] = 1'b0;
                k[i]   = 0;
            end else if (start && (!ran[i] || k[i] >= 8 * (dw[i] + 1))) begin
                ran[i]   = 1'b1;
                k[i]     = 0;
                smode[i] = mode;
            end else if (ran[i] && k[i] < 8 * (dw[i] + 1)) begin
                k[i] = k[i] + 1;
            end
        end
    end

    task automatic check_inst(input int i, input logic bz, input logic dn, input logic ps,
                              input int er, input int fv, input logic [2:0] stim, input bit unk);
        int len, n, cnt, e_fv, e_err, e_vec;
        bit e_busy, e_done, e_pass, first;
        len = 8 * (dw[i] + 1);
        e_busy = 0; e_done = 0; e_pass = 0; e_err = 0; e_fv = 0; e_vec = 0;
        if (ran[i]) begin
            e_busy = (k[i] < len);
            e_done = !e_busy;
            e_vec  = e_busy ? k[i] / (dw[i] + 1) : 0;
            n = k[i] / (dw[i] + 1);
            if (n > 8) n = 8;
            cnt = 0; first = 1;
            for (int v = 0; v < n; v++) begin
                if (dut_fn(smode[i], 3'(v)) != fs_ref(3'(v))) begin
                    if (first) e_fv = v;
                    first = 0;
                    cnt++;
                end
            end
            e_err  = (cnt > (1 << wd[i]) - 1) ? (1 << wd[i]) - 1 : cnt;
            e_pass = e_done && (cnt == 0);
        end
        chk("unknown_out", i, int'(unk), 0);
        chk("busy", i, int'(bz), int'(e_busy));
        chk("done", i, int'(dn), int'(e_done));
        chk("pass", i, int'(ps), int'(e_pass));
        chk("err_cnt", i, er, e_err);
        chk("fail_vec", i, fv, e_fv);
        chk("stim", i, int'(stim), e_vec);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_inst(0, busy0, done0, pass0, int'(err0), int'(fv0), {a0, b0, bin0},
                       $isunknown({a0, b0, bin0, busy0, done0, pass0, err0, fv0}));
            check_inst(1, busy1, done1, pass1, int'(err1), int'(fv1), {a1, b1, bin1},
                       $isunknown({a1, b1, bin1, busy1, done1, pass1, err1, fv1}));
        end
    end

    task automatic pulse_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    // Runs one sweep; c0/c1 are cycles from the accepting edge until each done rises
    task automatic sweep(input int m, output int c0, output int c1);
        mode = m;
        pulse_start();
        c0 = 0; c1 = 0;
        while (!done0 && c0 < 200) begin
            @(posedge clk); #1;
            c0++;
            if (done1 && c1 == 0) c1 = c0;
        end
        if (!done0) chk("sweep_timeout", 0, 0, 1);
    endtask

    initial begin
        int c0, c1;
        rst = 1'b1; start = 1'b0; mode = 0; chk_en = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("rst_busy", 0, int'(busy0), 0);
        chk("rst_done", 0, int'(done0), 0);
        chk("rst_err", 0, int'(err0), 0);

        sweep(0, c0, c1);
        chk("len_d10", 0, c0, 88);
        chk("len_d1", 1, c1, 16);
        chk("good_pass", 0, int'(pass0), 1);
        chk("good_pass", 1, int'(pass1), 1);

        sweep(1, c0, c1);
        chk("bout0_err", 0, int'(err0), 4);
        chk("bout0_fv", 0, int'(fv0), 1);
        chk("bout0_pass", 0, int'(pass0), 0);
        chk("bout0_err_sat", 1, int'(err1), 3);

        sweep(2, c0, c1);
        chk("dinv_err", 0, int'(err0), 8);
        chk("dinv_fv", 0, int'(fv0), 0);
        chk("dinv_err_sat", 1, int'(err1), 3);
        chk("dinv_pass", 1, int'(pass1), 0);

        sweep(3, c0, c1);
        chk("noborrow_err", 0, int'(err0), 4);
        chk("noborrow_fv", 0, int'(fv0), 1);

        // Reset while vector 4 is being applied
        mode = 1;
        pulse_start();
        repeat (47) @(posedge clk);
        #1;
        chk("pre_rst_err", 0, int'(err0), 3);
        chk("pre_rst_stim", 0, int'({a0, b0, bin0}), 4);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_stim", 0, int'({a0, b0, bin0}), 0);
        chk("rst_mid_busy", 0, int'(busy0), 0);
        chk("rst_mid_err", 0, int'(err0), 0);
        @(posedge clk); #2 rst = 1'b0;
        sweep(0, c0, c1);
        chk("post_rst_len", 0, c0, 88);
        chk("post_rst_pass", 0, int'(pass0), 1);

        // Start at cycle 20 of a sweep is ignored; start in DONE restarts and clears
        mode = 3;
        pulse_start();
        c0 = 0;
        repeat (18) begin @(posedge clk); c0++; end
        @(posedge clk); c0++; #2 start = 1'b1;
        @(posedge clk); c0++; #2 start = 1'b0;
        while (!done0 && c0 < 200) begin
            @(posedge clk); #1;
            c0++;
        end
        chk("busy_start_len", 0, c0, 88);
        chk("busy_start_err", 0, int'(err0), 4);
        pulse_start();
        #1;
        chk("restart_done", 0, int'(done0), 0);
        chk("restart_err", 0, int'(err0), 0);
        chk("restart_fv", 0, int'(fv0), 0);
        chk("restart_busy", 0, int'(busy0), 1);
        c0 = 0;
        while (!done0 && c0 < 200) begin
            @(posedge clk); #1;
            c0++;
        end
        chk("restart_len", 0, c0, 88);
        chk("restart_final_err", 0, int'(err0), 4);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
